// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the intr_ctrl interrupt controller.
//   - intc_state_e     : request/acknowledge sequencer states
//   - INTC_VEC_BASE    : default handler address of source 0
//   - INTC_VEC_STRIDE  : default byte spacing between per-source handlers
//   - intc_vector()    : handler address for a source index, modulo 2^32
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_INSVC = 2'd2
    } intc_state_e;

    localparam logic [31:0] INTC_VEC_BASE   = 32'h0000_0008;
    localparam int unsigned INTC_VEC_STRIDE = 4;

    // 32-bit arithmetic wraps naturally, giving the modulo-2^32 result.
    function automatic logic [31:0] intc_vector(input logic [31:0] base,
                                                input int unsigned stride,
                                                input int unsigned idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: source inputs, mask access and CPU intr/inta/eoi handshake
// of the interrupt controller.
//   master : controller side (drives intr, id, vector, mask, pending)
//   slave  : CPU / environment side (drives src, mask_we, mask_wdata, inta, eoi)
interface intr_ctrl_if #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
);
    logic [NSRC-1:0] src;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pending;
    logic            intr;
    logic            inta;
    logic            eoi;
    logic [IDW-1:0]  id;
    logic [31:0]     vector;

    modport master (
        input  src, mask_we, mask_wdata, inta, eoi,
        output mask, pending, intr, id, vector
    );

    modport slave (
        output src, mask_we, mask_wdata, inta, eoi,
        input  mask, pending, intr, id, vector
    );
endinterface

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: fixed-priority encoder, bit 0 has the highest priority.
//   eligible : NSRC-bit request vector
//   index    : lowest set bit position (0 when nothing is set)
//   valid    : at least one bit of eligible is set
// Purely combinational.
module intc_prio_enc #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic [NSRC-1:0] eligible,
    output logic [IDW-1:0]  index,
    output logic            valid
);

    // Scan from the top down so the lowest set bit is the last to write.
    always_comb begin
        index = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                index = IDW'(i);
            end
        end
    end

    assign valid = |eligible;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: device-side interrupt controller for the CPU intr/inta/eoi
// handshake. Latches source rising edges into pending, applies a writable
// mask, requests the CPU with the highest-priority eligible source, latches
// id/vector on acknowledge and waits for end-of-interrupt.
//
// Ports:
//   clk   : system clock, rising edge
//   clrn  : synchronous active-high reset
//   bus   : intr_ctrl_if.master (src, mask_we/mask_wdata/mask, pending,
//           intr, inta, eoi, id, vector)
//
// Build option INTC_LEVEL_EN: when defined, sources are level-sensitive
// (pending follows src directly, acknowledge does not clear anything).
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | no request outstanding, waiting for an eligible source
// ST_REQ   | intr asserted, winner re-evaluated each cycle until inta
// ST_INSVC | acknowledged source in service, waiting for eoi
module intr_ctrl
    import intc_pkg::*;
#(
    parameter int          NSRC       = 8,
    parameter int          IDW        = 3,
    parameter logic [31:0] VEC_BASE   = INTC_VEC_BASE,
    parameter int unsigned VEC_STRIDE = INTC_VEC_STRIDE
) (
    input logic         clk,
    input logic         clrn,
    intr_ctrl_if.master bus
);

    intc_state_e     state_q, state_d;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] elig;
    logic [IDW-1:0]  winner;
    logic            win_valid;
    logic [IDW-1:0]  id_q;
    logic [31:0]     vector_q;
    logic            ack;

`ifdef INTC_LEVEL_EN
    assign pend = bus.src;
`else
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr_vec;

    assign rise    = bus.src & ~src_q;
    assign clr_vec = ack ? (NSRC'(1) << winner) : '0;

    // OR-ing rise after the clear lets a new edge win over the acknowledge.
    always_ff @(posedge clk) begin
        if (clrn) begin
            src_q  <= '0;
            pend_q <= '0;
        end else begin
            src_q  <= bus.src;
            pend_q <= (pend_q & ~clr_vec) | rise;
        end
    end

    assign pend = pend_q;
`endif

    assign elig = pend & ~mask_q;

    intc_prio_enc #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_prio (
        .eligible (elig),
        .index    (winner),
        .valid    (win_valid)
    );

    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A request masked away before inta is withdrawn.
                if (!win_valid) begin
                    state_d = ST_IDLE;
                end else if (bus.inta) begin
                    ack     = 1'b1;
                    state_d = ST_INSVC;
                end
            end
            ST_INSVC: begin
                if (bus.eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q  <= ST_IDLE;
            mask_q   <= '1;
            id_q     <= '0;
            vector_q <= VEC_BASE;
        end else begin
            state_q <= state_d;
            if (bus.mask_we) begin
                mask_q <= bus.mask_wdata;
            end
            if (ack) begin
                id_q     <= winner;
                vector_q <= intc_vector(VEC_BASE, VEC_STRIDE, 32'(winner));
            end
        end
    end

    assign bus.intr    = (state_q == ST_REQ);
    assign bus.id      = id_q;
    assign bus.vector  = vector_q;
    assign bus.mask    = mask_q;
    assign bus.pending = pend;

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    logic clk  = 1'b0;
    logic clrn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    intr_ctrl_if #(.NSRC(8), .IDW(3)) bus ();

    intr_ctrl #(
        .NSRC       (8),
        .IDW        (3),
        .VEC_BASE   (32'h0000_0008),
        .VEC_STRIDE (4)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: what the CPU should observe, derived from the rules
    // "pend on rising edge, lowest unmasked index wins, request -> ack ->
    // service -> eoi".
    logic [7:0]  m_pend;
    logic [7:0]  m_srcq;
    logic [7:0]  m_mask;
    bit          m_req;
    bit          m_busy;
    logic [2:0]  m_id;
    logic [31:0] m_vec;

    function automatic void model_step();
        logic [7:0] cur;
        logic [7:0] elig;
        logic [7:0] rise;
        logic [7:0] nxt;
        int w;
        if (clrn) begin
            m_srcq = 8'h00;
            m_mask = 8'hFF;
            m_req  = 0;
            m_busy = 0;
            m_id   = 3'd0;
            m_vec  = 32'h8;
`ifdef INTC_LEVEL_EN
            m_pend = bus.src;
`else
            m_pend = 8'h00;
`endif
            return;
        end
`ifdef INTC_LEVEL_EN
        cur = bus.src;
`else
        cur = m_pend;
`endif
        elig = cur & ~m_mask;
        w = -1;
        for (int i = 0; i < 8; i++) begin
            if (w < 0 && elig[i]) w = i;
        end
        rise = bus.src & ~m_srcq;
        nxt  = m_pend | rise;
        if (m_req) begin
            if (w < 0) begin
                m_req = 0;
            end else if (bus.inta) begin
                m_id   = 3'(w);
                m_vec  = 32'h8 + 32'(w) * 4;
                nxt    = (m_pend & ~(8'd1 << w)) | rise;
                m_req  = 0;
                m_busy = 1;
            end
        end else if (m_busy) begin
            if (bus.eoi) m_busy = 0;
        end else if (w >= 0) begin
            m_req = 1;
        end
`ifdef INTC_LEVEL_EN
        m_pend = bus.src;
`else
        m_pend = nxt;
`endif
        m_srcq = bus.src;
        if (bus.mask_we) m_mask = bus.mask_wdata;
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b1;
        cyc();
        cyc();
        clrn = 1'b0;
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL reset_intr got %b exp 0", bus.intr); end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h exp 00", bus.pending); end
        checks++; if (bus.mask !== 8'hFF) begin errors++; $display("FAIL reset_mask got %h exp ff", bus.mask); end
        checks++; if (bus.id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", bus.id); end
        checks++; if (bus.vector !== 32'h8) begin errors++; $display("FAIL reset_vector got %h exp 00000008", bus.vector); end
    endtask

`ifndef INTC_LEVEL_EN
    task automatic test_edge_basic();
        bus.mask_we = 1'b1; bus.mask_wdata = 8'hFE;
        cyc();
        bus.mask_we = 1'b0;
        checks++; if (bus.mask !== 8'hFE) begin errors++; $display("FAIL basic_mask got %h exp fe", bus.mask); end
        bus.src = 8'h01;
        cyc();
        checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL basic_pend got %h exp 01", bus.pending); end
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL basic_intr_early got %b exp 0", bus.intr); end
        bus.src = 8'h00;
        cyc();
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL basic_intr got %b exp 1", bus.intr); end
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd0) begin errors++; $display("FAIL basic_id got %0d exp 0", bus.id); end
        checks++; if (bus.vector !== 32'h8) begin errors++; $display("FAIL basic_vector got %h exp 00000008", bus.vector); end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL basic_pend_clr got %h exp 00", bus.pending); end
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL basic_intr_drop got %b exp 0", bus.intr); end
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
    endtask

    task automatic test_priority();
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h00;
        cyc();
        bus.mask_we = 1'b0;
        bus.src = 8'h24;
        cyc();
        bus.src = 8'h00;
        cyc();
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL prio_intr got %b exp 1", bus.intr); end
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd2) begin errors++; $display("FAIL prio_id2 got %0d exp 2", bus.id); end
        checks++; if (bus.vector !== 32'h10) begin errors++; $display("FAIL prio_vec2 got %h exp 00000010", bus.vector); end
        checks++; if (bus.pending !== 8'h20) begin errors++; $display("FAIL prio_pend got %h exp 20", bus.pending); end
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL prio_eoi_gap got %b exp 0", bus.intr); end
        cyc();
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL prio_rereq got %b exp 1", bus.intr); end
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd5) begin errors++; $display("FAIL prio_id5 got %0d exp 5", bus.id); end
        checks++; if (bus.vector !== 32'h1C) begin errors++; $display("FAIL prio_vec5 got %h exp 0000001c", bus.vector); end
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
    endtask

    task automatic test_insvc_pend();
        bus.src = 8'h02;
        cyc();
        bus.src = 8'h00;
        cyc();
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd1) begin errors++; $display("FAIL insvc_id1 got %0d exp 1", bus.id); end
        bus.src = 8'h08;
        cyc();
        bus.src = 8'h00;
        cyc();
        checks++; if (bus.pending !== 8'h08) begin errors++; $display("FAIL insvc_pend got %h exp 08", bus.pending); end
        cyc();
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL insvc_intr got %b exp 0", bus.intr); end
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL insvc_eoi_gap got %b exp 0", bus.intr); end
        cyc();
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL insvc_rereq got %b exp 1", bus.intr); end
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd3) begin errors++; $display("FAIL insvc_id3 got %0d exp 3", bus.id); end
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
    endtask

    task automatic test_mask_drop();
        bus.src = 8'h10;
        cyc();
        bus.src = 8'h00;
        cyc();
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL mask_req got %b exp 1", bus.intr); end
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h10;
        cyc();
        bus.mask_we = 1'b0;
        cyc();
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL mask_drop got %b exp 0", bus.intr); end
        checks++; if (bus.pending !== 8'h10) begin errors++; $display("FAIL mask_keep_pend got %h exp 10", bus.pending); end
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h00;
        cyc();
        bus.mask_we = 1'b0;
        cyc();
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL mask_return got %b exp 1", bus.intr); end
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd4) begin errors++; $display("FAIL mask_id4 got %0d exp 4", bus.id); end
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
    endtask

    task automatic test_reset_midservice();
        bus.src = 8'h40;
        cyc();
        bus.src = 8'h00;
        cyc();
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd6) begin errors++; $display("FAIL rstmid_id6 got %0d exp 6", bus.id); end
        bus.src = 8'h02;
        cyc();
        bus.src = 8'h00;
        cyc();
        clrn = 1'b1;
        cyc();
        clrn = 1'b0;
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL rstmid_intr got %b exp 0", bus.intr); end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rstmid_pend got %h exp 00", bus.pending); end
        checks++; if (bus.mask !== 8'hFF) begin errors++; $display("FAIL rstmid_mask got %h exp ff", bus.mask); end
        checks++; if (bus.id !== 3'd0) begin errors++; $display("FAIL rstmid_id got %0d exp 0", bus.id); end
        checks++; if (bus.vector !== 32'h8) begin errors++; $display("FAIL rstmid_vec got %h exp 00000008", bus.vector); end
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
        cyc();
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL rstmid_eoi got %b exp 0", bus.intr); end
    endtask
`else
    task automatic test_level();
        bus.mask_we = 1'b1; bus.mask_wdata = 8'h00;
        cyc();
        bus.mask_we = 1'b0;
        bus.src = 8'h40;
        cyc();
        checks++; if (bus.pending !== 8'h40) begin errors++; $display("FAIL lvl_pend got %h exp 40", bus.pending); end
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL lvl_intr got %b exp 1", bus.intr); end
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd6) begin errors++; $display("FAIL lvl_id6 got %0d exp 6", bus.id); end
        checks++; if (bus.vector !== 32'h20) begin errors++; $display("FAIL lvl_vec got %h exp 00000020", bus.vector); end
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL lvl_intr_drop got %b exp 0", bus.intr); end
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL lvl_eoi_gap got %b exp 0", bus.intr); end
        cyc();
        checks++; if (bus.intr !== 1'b1) begin errors++; $display("FAIL lvl_rereq got %b exp 1", bus.intr); end
        bus.inta = 1'b1;
        cyc();
        bus.inta = 1'b0;
        checks++; if (bus.id !== 3'd6) begin errors++; $display("FAIL lvl_id6b got %0d exp 6", bus.id); end
        bus.src = 8'h00;
        cyc();
        bus.eoi = 1'b1;
        cyc();
        bus.eoi = 1'b0;
        cyc();
        cyc();
        checks++; if (bus.intr !== 1'b0) begin errors++; $display("FAIL lvl_no_rereq got %b exp 0", bus.intr); end
        checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL lvl_pend_drop got %h exp 00", bus.pending); end
    endtask
`endif

    task automatic test_random();
        clrn = 1'b1;
        cyc();
        clrn = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bus.src     = bus.src ^ 8'($urandom & $urandom);
            bus.mask_we = ($urandom_range(0, 9) == 0);
            bus.mask_wdata = 8'($urandom & $urandom & $urandom);
            bus.inta    = m_req  ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            bus.eoi     = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            clrn        = ($urandom_range(0, 99) == 0);
            cyc();
            checks++; if (bus.intr !== 1'(m_req)) begin errors++; $display("FAIL rnd_intr cyc %0d got %b exp %b", n, bus.intr, m_req); end
            checks++; if (bus.pending !== m_pend) begin errors++; $display("FAIL rnd_pend cyc %0d got %h exp %h", n, bus.pending, m_pend); end
            checks++; if (bus.mask !== m_mask) begin errors++; $display("FAIL rnd_mask cyc %0d got %h exp %h", n, bus.mask, m_mask); end
            checks++; if (bus.id !== m_id) begin errors++; $display("FAIL rnd_id cyc %0d got %0d exp %0d", n, bus.id, m_id); end
            checks++; if (bus.vector !== m_vec) begin errors++; $display("FAIL rnd_vec cyc %0d got %h exp %h", n, bus.vector, m_vec); end
        end
        clrn = 1'b0;
        bus.inta = 1'b0;
        bus.eoi = 1'b0;
        bus.mask_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src        = 8'h00;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = 8'h00;
        bus.inta       = 1'b0;
        bus.eoi        = 1'b0;
        m_pend = 8'h00; m_srcq = 8'h00; m_mask = 8'hFF;
        m_req = 0; m_busy = 0; m_id = 3'd0; m_vec = 32'h8;
        @(posedge clk);
        #1;
        test_reset();
`ifndef INTC_LEVEL_EN
        test_edge_basic();
        test_priority();
        test_insvc_pend();
        test_mask_drop();
        test_reset_midservice();
`else
        test_level();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Interrupt controller on the device side of the CPU's intr/inta handshake; the CPU core is the responder. It collects NSRC interrupt sources, latches rising edges into a pending register, applies a software-writable mask and picks the highest-priority request. It raises intr, accepts the CPU's inta acknowledge, presents the 32-bit handler vector and source id, then waits for end-of-interrupt (eoi) before raising the next request.

Parameters:
NSRC, 8, number of interrupt sources (2..32)
IDW, 3, width of source id; must equal clog2(NSRC)
VEC_BASE, 32'h0000_0008, handler address of source 0
VEC_STRIDE, 4, byte spacing between per-source handler addresses

Ports:
clk  in  1  system clock; all state changes on rising edge
clrn  in  1  reset; synchronous, active-high (name kept for codebase consistency; polarity and synchronicity fixed as stated)
src  in  NSRC  raw interrupt sources, already synchronous to clk
mask_we  in  1  write strobe for mask register
mask_wdata  in  NSRC  new mask value; bit=1 masks that source
mask  out  NSRC  current mask register
pending  out  NSRC  current pending register
intr  out  1  interrupt request to CPU
inta  in  1  acknowledge from CPU, single-cycle pulse
eoi  in  1  end-of-interrupt from CPU, single-cycle pulse
id  out  IDW  id of acknowledged source
vector  out  32  handler address = VEC_BASE + id*VEC_STRIDE, modulo 2^32

Behaviour:
- Reset (clrn=1 at an edge): src_q=0, pending=0, mask=all ones, state=IDLE, intr=0, id=0, vector=VEC_BASE. Reset mid-handshake abandons the request; the in-service source is not re-pended.
- Edge detect: src_q <= src every cycle; rise = src & ~src_q; pending bit i set at the edge after src[i] rises (1-cycle latency from the sampled rise).
- Mask: mask_we=1 loads mask_wdata at the edge. Masking never clears pending; unmasking a pending bit makes it eligible the next cycle.
- Eligible = pending & ~mask; winner = lowest set index (bit 0 highest priority).
- FSM states IDLE, REQ, INSVC:
  IDLE: if eligible != 0 -> REQ, with intr=1 from the next cycle.
  REQ: intr=1. If eligible == 0 (e.g. masked meanwhile) -> IDLE, intr=0 next cycle. Else if inta=1 -> latch id=winner and vector, clear pending[winner], go INSVC, intr=0 next cycle. Winner is re-evaluated every REQ cycle; the latched id is the winner in the inta cycle.
  INSVC: intr=0; new edges still pend. eoi=1 -> IDLE. Earliest next intr assertion is 2 cycles after eoi.
- inta outside REQ and eoi outside INSVC are ignored.
- Same-cycle set and clear of one pending bit: set wins, so the bit stays pending.
- id and vector hold their values until the next acknowledge.
- src held high produces exactly one pending event per rising edge.

Optional Feature:
Macro INTC_LEVEL_EN. When defined, sources are level-sensitive: pending = src (combinational register bypass; no edge latch) and the acknowledge clear has no effect. The source must drop its line before eoi, or it is requested again. When undefined, sources are edge-triggered as above.

Decomposition:
- Shared package intc_pkg: state encoding (IDLE/REQ/INSVC), default VEC_BASE and VEC_STRIDE constants.
- One sub-module, intc_prio_enc: NSRC-bit eligible vector in, IDW-bit index plus valid out, purely combinational.

Test Plan:
- Reset, then mask_wdata=8'hFE with mask_we; pulse src[0] -> pending[0]=1 next cycle, intr=1 one cycle later; inta -> id=0, vector=32'h8, pending[0]=0, intr=0 next cycle.
- Unmask all; raise src[5] and src[2] in the same cycle; inta -> id=2, vector=32'h10; eoi -> intr re-asserts 2 cycles later; inta -> id=5, vector=32'h1C.
- src[3] rises while in INSVC for source 1 -> pending[3]=1, intr stays 0 until eoi, then request for id 3.
- In REQ for source 4, write mask bit 4=1 with nothing else eligible -> intr drops next cycle, pending[4] remains 1; unmask -> intr returns.
- Assert clrn in INSVC -> next cycle intr=0, pending=0, mask=8'hFF, id=0, vector=32'h8; a following eoi has no effect.
- With INTC_LEVEL_EN: hold src[6] high through eoi -> intr re-asserts with id=6; drop src[6] before eoi -> no re-request.
